// File: rtl/aes_block_loader.sv
// Word-serial loader for the AES-128 datapath: gathers key and plaintext words,
// applies the initial AddRoundKey and holds the round-0 state in an output register.
module aes_block_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_is_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [127:0] out_key,
  output logic         err
);

  logic [127:0] key_reg;
  logic [127:0] text_reg;
  logic [1:0]   key_cnt;
  logic [1:0]   text_cnt;
  logic         key_valid;
  logic         text_full;

  logic         accept;
  logic         key_acc;
  logic         text_acc;
  logic         key_abort;
  logic         text_abort;
  logic         transfer;
  logic [6:0]   key_base;
  logic [6:0]   text_base;

  assign s_ready    = ~text_full;
  assign accept     = s_valid & s_ready;
  assign key_acc    = accept & s_is_key;
  assign text_acc   = accept & ~s_is_key;
  // a word of one kind arriving mid-group of the other kind kills that group
  assign text_abort = key_acc & (text_cnt != 2'd0);
  assign key_abort  = text_acc & (key_cnt != 2'd0);
  assign transfer   = text_full & key_valid & (~out_valid | out_ready);

  // slot 0 is the most significant word
  assign key_base   = {~key_cnt, 5'd0};
  assign text_base  = {~text_cnt, 5'd0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg   <= '0;
      key_cnt   <= '0;
      key_valid <= 1'b0;
    end else if (key_acc) begin
      key_reg[key_base +: 32] <= s_data;
      key_cnt <= key_cnt + 2'd1;
      if (key_cnt == 2'd0)
        key_valid <= 1'b0;
      else if (key_cnt == 2'd3)
        key_valid <= 1'b1;
    end else if (key_abort) begin
      key_cnt   <= '0;
      key_valid <= 1'b0;
    end
  end

  // text_acc and transfer are exclusive: s_ready is low whenever text_full is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      text_reg  <= '0;
      text_cnt  <= '0;
      text_full <= 1'b0;
    end else begin
      if (text_acc) begin
        text_reg[text_base +: 32] <= s_data;
        text_cnt <= text_cnt + 2'd1;
        if (text_cnt == 2'd3)
          text_full <= 1'b1;
      end else if (text_abort) begin
        text_cnt <= '0;
      end
      if (transfer)
        text_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_state <= '0;
      out_key   <= '0;
      err       <= 1'b0;
    end else begin
      err <= text_abort | key_abort;
      if (transfer) begin
        out_state <= text_reg ^ key_reg;
        out_key   <= key_reg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
